// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : Oversampling serial byte receiver (8N1; 8E1 when the macro
//               UART_RX_PARITY_EN is defined) with framing/parity error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int                  c_cnt_w     = $clog2(CLKS_PER_BIT);
  localparam logic [c_cnt_w-1:0]  c_half_last = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_cnt_w-1:0]  c_full_last = c_cnt_w'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  logic [1:0]         r_sync;
  logic               w_rx_s;
  state_t             r_state,  w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt,    w_cnt_nxt;
  logic [2:0]         r_idx,    w_idx_nxt;
  logic [7:0]         r_shift,  w_shift_nxt;
  logic [7:0]         r_data,   w_data_nxt;
  logic               r_valid,  w_valid_nxt;
  logic               r_ferr,   w_ferr_nxt;
  logic               r_perr,   w_perr_nxt;
  logic               w_pbad;

  assign w_rx_s = r_sync[1];

`ifdef UART_RX_PARITY_EN
  logic r_pbad, w_pbad_nxt;
  assign w_pbad = r_pbad;
`else
  // No parity bit: mismatch can never occur, so parity_err stays low.
  assign w_pbad = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
    w_perr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_pbad_nxt  = r_pbad;
`endif
    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
`ifdef UART_RX_PARITY_EN
          w_pbad_nxt  = 1'b0;
`endif
        end
      end
      S_START: begin
        if (r_cnt == c_half_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (r_cnt == c_full_last) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rx_s, r_shift[7:1]};  // LSB arrives first
          w_idx_nxt   = r_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (r_idx == 3'd7) w_state_nxt = S_PARITY;
`else
          if (r_idx == 3'd7) w_state_nxt = S_STOP;
`endif
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (r_cnt == c_full_last) begin
          w_cnt_nxt   = '0;
          w_pbad_nxt  = w_rx_s ^ (^r_shift);
          w_state_nxt = S_STOP;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (r_cnt == c_full_last) begin
          w_cnt_nxt = '0;
          if (w_rx_s) begin
            w_state_nxt = S_IDLE;
            if (w_pbad) begin
              w_perr_nxt = 1'b1;
            end else begin
              w_data_nxt  = r_shift;
              w_valid_nxt = 1'b1;
            end
          end else begin
            w_ferr_nxt  = 1'b1;
            w_perr_nxt  = w_pbad;
            w_state_nxt = S_BREAK;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_BREAK: begin
        // A line held low reports a single frame error, then waits for idle.
        if (w_rx_s) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync  <= 2'b11;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_pbad  <= 1'b0;
`endif
    end else begin
      r_sync  <= {r_sync[0], rx};
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
      r_perr  <= w_perr_nxt;
`ifdef UART_RX_PARITY_EN
      r_pbad  <= w_pbad_nxt;
`endif
    end
  end

  assign data       = r_data;
  assign valid      = r_valid;
  assign frame_err  = r_ferr;
  assign parity_err = r_perr;
  assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for uart_rx: frames are driven bit-by-bit and each output event is
// compared with a frame-level model (expected cycle, flags and held byte).
module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int NBITS = PAR_EN ? 11 : 10;
  // rx drop -> 2 sync cycles to T, half bit to start check, stop bit is
  // frame bit NBITS-1, outputs one cycle after the stop sample.
  localparam int LAT = 2 + CPB / 2 + (NBITS - 1) * CPB + 1;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx      = 1'b1;
  logic [7:0] data;
  logic       valid, frame_err, parity_err, busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct packed {
    logic [31:0] cyc;
    logic [2:0]  flags;   // {valid, frame_err, parity_err}
    logic [7:0]  data;
  } ev_t;
  ev_t obs[$];

  logic [7:0] model_data = 8'h00;
  logic [7:0] prev_data  = 8'h00;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      if (valid || frame_err || parity_err)
        obs.push_back({32'(cyc), valid, frame_err, parity_err, data});
      if (data !== prev_data) chk("data_only_with_valid", {31'b0, valid}, 32'd1);
    end
    prev_data <= data;
  end

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop, output int fall);
    logic [10:0] bits;
    bits = {stop, stop, b, 1'b0};
    if (PAR_EN) bits = {stop, par, b, 1'b0};
    fall = cyc;
    for (int i = 0; i < NBITS; i++) begin
      rx = bits[i];
      repeat (CPB) @(negedge clock);
    end
  endtask

  task automatic expect_frame(input logic [7:0] b, input logic par, input logic stop, input int fall);
    logic perr;
    ev_t  e;
    perr = PAR_EN && (par != ^b);
    if (stop && !perr) model_data = b;
    chk("event_present", {31'b0, obs.size() > 0}, 32'd1);
    if (obs.size() > 0) begin
      e = obs.pop_front();
      chk("event_cycle", e.cyc, 32'(fall + LAT));
      chk("event_flags", {29'b0, e.flags}, {29'b0, stop && !perr, !stop, perr});
      chk("event_data",  {24'b0, e.data}, {24'b0, model_data});
    end
  endtask

  initial begin
    int         fall, f0, f1, f2;
    logic [7:0] b;
    logic       p;

    repeat (3) @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
    chk("reset_data",       {24'b0, data}, 32'h0);
    chk("reset_valid",      {31'b0, valid}, 32'h0);
    chk("reset_frame_err",  {31'b0, frame_err}, 32'h0);
    chk("reset_parity_err", {31'b0, parity_err}, 32'h0);
    chk("reset_busy",       {31'b0, busy}, 32'h0);

    // Nominal frame
    b = 8'hA5;
    send_frame(b, ^b, 1'b1, fall);
    repeat (2 * CPB) @(negedge clock);
    expect_frame(b, ^b, 1'b1, fall);
    chk("a5_busy_after", {31'b0, busy}, 32'h0);
    chk("a5_no_extra", obs.size(), 32'd0);

    // Short low glitch must be rejected at the start-bit check
    fall = cyc;
    rx = 1'b0;
    repeat (4) @(negedge clock);
    rx = 1'b1;
    repeat (2 + CPB / 2 - 4) @(negedge clock);
    chk("glitch_busy_at_check", {31'b0, busy}, 32'h1);
    @(negedge clock);
    chk("glitch_busy_after", {31'b0, busy}, 32'h0);
    repeat (200) @(negedge clock);
    chk("glitch_no_event", obs.size(), 32'd0);
    chk("glitch_data", {24'b0, data}, {24'b0, model_data});

    // Random bytes with random idle gaps (and occasional bad parity)
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom);
      p = (^b) ^ ($urandom_range(0, 3) == 0);
      send_frame(b, p, 1'b1, fall);
      expect_frame(b, p, 1'b1, fall);
      repeat ($urandom_range(0, 20)) @(negedge clock);
    end
    chk("random_no_extra", obs.size(), 32'd0);

    // Stop bit low, line held low: one frame error only
    b = 8'h3C;
    send_frame(b, ^b, 1'b0, fall);
    repeat (40 * CPB) @(negedge clock);
    expect_frame(b, ^b, 1'b0, fall);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clock);
    chk("break_single_err", obs.size(), 32'd0);
    chk("break_busy_after", {31'b0, busy}, 32'h0);
    b = 8'h81;
    send_frame(b, ^b, 1'b1, fall);
    expect_frame(b, ^b, 1'b1, fall);

    // Back-to-back frames with no idle gap
    send_frame(8'h00, 1'b0, 1'b1, f0);
    send_frame(8'hFF, 1'b0, 1'b1, f1);
    send_frame(8'h55, 1'b0, 1'b1, f2);
    repeat (2 * CPB) @(negedge clock);
    expect_frame(8'h00, 1'b0, 1'b1, f0);
    expect_frame(8'hFF, 1'b0, 1'b1, f1);
    expect_frame(8'h55, 1'b0, 1'b1, f2);
    chk("b2b_no_extra", obs.size(), 32'd0);

    // Reset in the middle of data bit 4
    b = 8'h77;
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    rx = b[4];
    repeat (CPB / 2) @(negedge clock);
    chk("pre_reset_busy", {31'b0, busy}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    model_data = 8'h00;
    chk("midreset_busy",  {31'b0, busy}, 32'h0);
    chk("midreset_data",  {24'b0, data}, 32'h0);
    chk("midreset_flags", {29'b0, valid, frame_err, parity_err}, 32'h0);
    rx = 1'b1;
    @(negedge clock);
    #2 reset_n = 1'b1;
    repeat (3 * CPB) @(negedge clock);
    chk("midreset_no_event", obs.size(), 32'd0);
    b = 8'h12;
    send_frame(b, ^b, 1'b1, fall);
    expect_frame(b, ^b, 1'b1, fall);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, fall);
    expect_frame(8'h07, 1'b1, 1'b1, fall);
    send_frame(8'h07, 1'b0, 1'b1, fall);
    expect_frame(8'h07, 1'b0, 1'b1, fall);
    send_frame(8'h5A, 1'b1, 1'b1, fall);
    expect_frame(8'h5A, 1'b1, 1'b1, fall);
    chk("parity_no_extra", obs.size(), 32'd0);
`endif

    repeat (2 * CPB) @(negedge clock);
    chk("final_no_extra", obs.size(), 32'd0);
    chk("final_busy", {31'b0, busy}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Serial byte receiver for the host-to-FPGA direction of the board's UART link, complementing the existing `uart` transmitter that streams filtered samples out on `TX`. It runs in the `pll_uart` clock domain and oversamples the asynchronous `rx` line by `CLKS_PER_BIT`. Each received frame is delivered as an 8-bit word with a one-cycle `valid` strobe; framing and (optionally) parity errors are reported. It is the entry point for host control words such as NCO phase increment or gain selection.

## Interface
- `CLKS_PER_BIT`, 16: `clock` cycles per bit; even, ≥ 4; baud = f(`clock`)/`CLKS_PER_BIT`.
- `clock`  in  1  UART clock (`pll_uart` output).
- `reset_n`  in  1  Reset; one clock; reset is asynchronous and active-low.
- `rx`  in  1  Asynchronous serial input; idle high; 8 data bits, LSB first, 1 stop bit.
- `data`  out  8  Last received byte; held until the next accepted frame; reset 8'h00.
- `valid`  out  1  One-cycle pulse; `data` is new; reset 0.
- `frame_err`  out  1  One-cycle pulse; stop bit sampled low; reset 0.
- `parity_err`  out  1  One-cycle pulse; parity mismatch; reset 0; tied 0 without the macro.
- `busy`  out  1  High in every state except IDLE; reset 0.

## Operation
- `rx` passes through a 2-flop synchronizer (reset value 1) giving `rx_s`; all decisions use `rx_s`.
- States: IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
- IDLE: `rx_s`=0 -> START, bit counter `cnt` cleared, bit index cleared.
- START: `cnt` counts up; at `cnt`=`CLKS_PER_BIT`/2-1, `rx_s`=0 -> DATA (cnt cleared); `rx_s`=1 -> IDLE (glitch rejected, no output).
- DATA: at `cnt`=`CLKS_PER_BIT`-1 sample `rx_s` into shift register bit `idx` (LSB first), cnt cleared; after bit 7 -> PARITY or STOP.
- PARITY: sample at `cnt`=`CLKS_PER_BIT`-1, compare with even parity of the byte -> STOP.
- STOP: sample at `cnt`=`CLKS_PER_BIT`-1.
  - `rx_s`=1, no parity error: `data` <= shift register, `valid` pulse -> IDLE.
  - `rx_s`=1, parity error: `parity_err` pulse, `data` unchanged, no `valid` -> IDLE.
  - `rx_s`=0: `frame_err` pulse, no `valid`, `data` unchanged -> BREAK; also `parity_err` if mismatch.
- BREAK: wait for `rx_s`=1 -> IDLE (a line held low yields exactly one `frame_err`).
- IDLE re-arms in the cycle after STOP; a start bit immediately following the stop-bit sample point is accepted (back-to-back frames, no lost byte).
- `reset_n` low at any time: state -> IDLE, counters cleared, all outputs to reset values, synchronizer to 1; partial frame discarded.

## Timing
- Let T be the first cycle IDLE observes `rx_s`=0 (2 cycles after `rx` falls at a clock edge).
- Start verified at T+`CLKS_PER_BIT`/2; data bit i sampled at T+`CLKS_PER_BIT`/2+(i+1)·`CLKS_PER_BIT`.
- Stop sampled at T+`CLKS_PER_BIT`/2+9·`CLKS_PER_BIT` (10· with parity); `valid`/`frame_err`/`parity_err` high in the following cycle only.
- `data` changes only in the cycle `valid` is high.
- Tolerated baud mismatch: sample points stay inside bits for ±4 % clock error at `CLKS_PER_BIT`=16.

## Configuration
- `UART_RX_PARITY_EN` defined: frame is start, 8 data, even parity bit, stop; PARITY state present; `parity_err` driven.
- Undefined: no parity bit, PARITY state absent, `parity_err` constant 0; frame is 10 bits.

## Test plan
- `CLKS_PER_BIT`=16, send 0xA5 at nominal baud -> single `valid` at T+152+1, `data`=0xA5, no error pulses, `busy` low afterwards.
- `rx` low for 4 cycles then high -> START returns to IDLE at T+8; no `valid`, no error, `data` unchanged.
- Send 0x3C with stop bit low, `rx` held low 40 more bit times -> exactly one `frame_err`, no `valid`, `data` unchanged; next 0x81 after line idles -> `data`=0x81.
- Back-to-back 0x00, 0xFF, 0x55 with no idle gap -> three `valid` pulses, 160 cycles apart, in order.
- `reset_n` pulsed low during bit 4 of 0x77 -> outputs zero, `busy`=0 immediately; next frame 0x12 received correctly.
- With `UART_RX_PARITY_EN`: 0x07 with parity bit 1 -> `valid`, `data`=0x07; parity bit 0 -> `parity_err` only, `data` unchanged.
